bsg_two_fifo_w58: RTL and testbench

Two-element ready/valid FIFO, 58-bit payload, built around a 2-entry 1r1w register memory (synchronous write, asynchronous read). Sits directly upstream of the memory: owns head/tail pointers, full/empty state and the handshake, and drives the memory's write-valid, write-address and read-address. Used as a decoupling buffer between pipeline stages in bp_multi_top, giving full throughput with no combinational ready path from consumer to producer.

---
 rtl/bsg_two_fifo_pkg.sv | 19 +
 rtl/bsg_mem_1r1w_synth.sv | 39 +++
 rtl/bsg_two_fifo_w58.sv | 87 ++++++++
 tb/tb_bsg_two_fifo_w58.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bsg_two_fifo_pkg.sv
// Shared sizing and types for the two-element FIFO and its backing memory.
package bsg_two_fifo_pkg;

  localparam int unsigned width_p        = 58;
  localparam int unsigned els_p          = 2;
  localparam int unsigned ptr_width_lp   = 1;
  localparam int unsigned count_width_lp = 2;

  typedef logic [ptr_width_lp-1:0]   ptr_t;
  typedef logic [count_width_lp-1:0] count_t;

  // Occupancy from the full/empty flags; the two are never both set.
  function automatic count_t count_f(input logic full, input logic empty);
    if (full)       return count_t'(2);
    else if (empty) return count_t'(0);
    else            return count_t'(1);
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w_synth.sv
// Register-based 1r1w memory: synchronous write, asynchronous read, no reset.
module bsg_mem_1r1w_synth
  #(parameter int unsigned width_p               = 58
  , parameter int unsigned els_p                 = 2
  , parameter int unsigned read_write_same_addr_p = 0
  , localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
  )
  ( input  logic                     w_clk_i
  , input  logic                     w_v_i
  , input  logic [addr_width_lp-1:0] w_addr_i
  , input  logic [width_p-1:0]       w_data_i
  , input  logic [addr_width_lp-1:0] r_addr_i
  , output logic [width_p-1:0]       r_data_o
  );

  logic [width_p-1:0] mem_r [els_p];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  // Read port; the bypass only exists when callers may hit the same address.
  if (read_write_same_addr_p != 0) begin : g_bypass
    always_comb begin
      r_data_o = mem_r[r_addr_i];
      if (w_v_i && (w_addr_i == r_addr_i)) begin
        r_data_o = w_data_i;
      end
    end
  end else begin : g_plain
    always_comb begin
      r_data_o = mem_r[r_addr_i];
    end
  end

endmodule

// File: rtl/bsg_two_fifo_w58.sv
// Two-entry ready/valid FIFO with registered ready/valid and a sticky
// protocol-error flag; storage is a 2-entry 1r1w register memory.
module bsg_two_fifo_w58
  import bsg_two_fifo_pkg::*;
  ( input  logic               clk_i
  , input  logic               reset_i
  , input  logic               v_i
  , input  logic [width_p-1:0] data_i
  , output logic               ready_o
  , output logic               v_o
  , output logic [width_p-1:0] data_o
  , input  logic               yumi_i
  , output logic [1:0]         count_o
  , output logic               error_o
  );

  ptr_t head_r, head_n;
  ptr_t tail_r, tail_n;
  logic empty_r, empty_n;
  logic full_r,  full_n;
  logic error_r, error_n;
  logic enq_c, deq_c;

  // Control state; async reset drops outputs to idle without a clock edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_r  <= ptr_t'(0);
      tail_r  <= ptr_t'(0);
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      head_r  <= head_n;
      tail_r  <= tail_n;
      empty_r <= empty_n;
      full_r  <= full_n;
      error_r <= error_n;
    end
  end

  // Handshake qualification, pointer advance and full/empty update.
  always_comb begin
    head_n  = head_r;
    tail_n  = tail_r;
    empty_n = empty_r;
    full_n  = full_r;
    error_n = error_r;

    enq_c = v_i    & ~full_r;
    deq_c = yumi_i & ~empty_r;

    if (enq_c) tail_n = ~tail_r;
    if (deq_c) head_n = ~head_r;

    // A lone enq fills when one entry was held; a lone deq empties likewise.
    if (enq_c && !deq_c) begin
      empty_n = 1'b0;
      full_n  = ~empty_r;
    end else if (deq_c && !enq_c) begin
      full_n  = 1'b0;
      empty_n = ~full_r;
    end

    if (yumi_i && empty_r) error_n = 1'b1;
  end

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;
  assign error_o = error_r;
  assign count_o = count_f(full_r, empty_r);

  // head==tail only when empty or full, so the read never collides with a write.
  bsg_mem_1r1w_synth
    #(.width_p               (width_p)
     ,.els_p                 (els_p)
     ,.read_write_same_addr_p(0)
     )
  mem
    (.w_clk_i (clk_i)
    ,.w_v_i   (enq_c)
    ,.w_addr_i(tail_r)
    ,.w_data_i(data_i)
    ,.r_addr_i(head_r)
    ,.r_data_o(data_o)
    );

endmodule

// File: tb/tb_bsg_two_fifo_w58.sv
// Self-checking bench for bsg_two_fifo_w58 against a queue-based model.
module tb_bsg_two_fifo_w58;

  localparam int unsigned W = 58;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         ready_o;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i;
  logic [1:0]   count_o;
  logic         error_o;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q[$];
  logic         err_m;

  always #5 clk_i = ~clk_i;

  bsg_two_fifo_w58 dut
    (.clk_i  (clk_i)
    ,.reset_i(reset_i)
    ,.v_i    (v_i)
    ,.data_i (data_i)
    ,.ready_o(ready_o)
    ,.v_o    (v_o)
    ,.data_o (data_o)
    ,.yumi_i (yumi_i)
    ,.count_o(count_o)
    ,.error_o(error_o)
    );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model.
  task automatic check_all(input string tag);
    check({tag, ".ready"}, 64'(ready_o), 64'(q.size() < 2));
    check({tag, ".v"},     64'(v_o),     64'(q.size() > 0));
    check({tag, ".count"}, 64'(count_o), 64'(q.size()));
    check({tag, ".error"}, 64'(error_o), 64'(err_m));
    if (q.size() > 0) check({tag, ".data"}, 64'(data_o), 64'(q[0]));
  endtask

  // One clock: drive at negedge, model the edge, check at next negedge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic y, input string tag);
    bit enq, deq;
    v_i = v; data_i = d; yumi_i = y;
    enq = v && (q.size() < 2);
    deq = y && (q.size() > 0);
    if (y && q.size() == 0) err_m = 1'b1;
    @(posedge clk_i);
    if (deq) void'(q.pop_front());
    if (enq) q.push_back(d);
    @(negedge clk_i);
    check_all(tag);
  endtask

  // Async reset mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2 reset_i = 1'b1;
    q.delete();
    err_m = 1'b0;
    #1 check_all(tag);
    @(negedge clk_i);
    check_all({tag, ".held"});
    reset_i = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  initial begin
    reset_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; err_m = 1'b0;
    @(negedge clk_i);
    async_reset("reset");

    // Fill, blocked third enq, drain in order.
    cycle(1'b1, 58'h2AAAAAAAAAAAAAA, 1'b0, "fill0");
    cycle(1'b1, 58'h155555555555555, 1'b0, "fill1");
    cycle(1'b1, 58'h3FFFFFFFFFFFFFF, 1'b0, "fill_blocked");
    cycle(1'b0, '0, 1'b1, "drain0");
    cycle(1'b0, '0, 1'b1, "drain1");
    cycle(1'b0, '0, 1'b0, "idle");

    // Streaming at count 1.
    cycle(1'b1, W'(0), 1'b0, "stream_first");
    for (int i = 1; i < 100; i++) cycle(1'b1, W'(i), 1'b1, "stream");
    cycle(1'b0, '0, 1'b1, "stream_tail");

    // Full plus deq with a competing enq.
    cycle(1'b1, W'(58'h111), 1'b0, "fd0");
    cycle(1'b1, W'(58'h222), 1'b0, "fd1");
    cycle(1'b1, W'(58'h333), 1'b1, "fd_deq_blocked");
    cycle(1'b1, W'(58'h444), 1'b0, "fd_enq_again");
    cycle(1'b0, '0, 1'b1, "fd_out0");
    cycle(1'b0, '0, 1'b1, "fd_out1");

    // Protocol error while empty, then sticky through traffic.
    cycle(1'b0, '0, 1'b1, "err_set");
    cycle(1'b1, W'(58'h5A5), 1'b0, "err_sticky0");
    cycle(1'b0, '0, 1'b1, "err_sticky1");

    // Reset at count 2, then fresh data is first out.
    cycle(1'b1, W'(58'hAAA), 1'b0, "rm0");
    cycle(1'b1, W'(58'hBBB), 1'b0, "rm1");
    v_i = 1'b1; yumi_i = 1'b1;
    async_reset("reset_mid");
    cycle(1'b1, W'(58'hCCC), 1'b0, "post_reset_enq");
    cycle(1'b0, '0, 1'b1, "post_reset_deq");

    // Random traffic, mostly legal yumi.
    for (int i = 0; i < 300; i++) begin
      logic y;
      y = ($urandom_range(0, 1) == 1) && (q.size() > 0 || $urandom_range(0, 15) == 0);
      cycle(1'($urandom_range(0, 1)), rnd(), y, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
